// File: rtl/reg_dump.sv
// Register-file dump engine: walks FIRST_REG..LAST_REG through one read port and
// streams each register as a header byte plus four big-endian data bytes.
module reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    state_t      state_q;
    logic [4:0]  index_q;
    logic [31:0] word_q;
    logic [2:0]  byte_idx_q;
    logic        busy_q;
    logic        done_q;
    logic        valid_q;
    logic [7:0]  data_q;
    logic        last_q;

    logic [2:0]  byte_idx_d;
    logic [4:0]  index_d;

    // Byte 0 is the header tagging the register index; bytes 1..4 are MSB first.
    function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                             input logic [2:0]  idx,
                                             input logic [4:0]  addr);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {3'b101, addr};
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Incremented counters for the SEND handshake.
    always_comb begin
        byte_idx_d = byte_idx_q + 3'd1;
        index_d    = index_q + 5'd1;
    end

    // Dump sequencer; all outputs come from registers, ena freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            index_q    <= FIRST_IDX;
            word_q     <= 32'h0000_0000;
            byte_idx_q <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
            last_q     <= 1'b0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    word_q     <= rd_data;
                    byte_idx_q <= 3'd0;
                    data_q     <= pick_byte(rd_data, 3'd0, index_q);
                    last_q     <= 1'b0;
                    valid_q    <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (byte_idx_q < 3'd4) begin
                            byte_idx_q <= byte_idx_d;
                            data_q     <= pick_byte(word_q, byte_idx_d, index_q);
                            last_q     <= (byte_idx_d == 3'd4) && (index_q == LAST_IDX);
                        end else if (index_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            index_q <= index_d;
                            state_q <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    index_q <= FIRST_IDX;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    index_q <= FIRST_IDX;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q & ena;
    assign rd_addr   = index_q;
    assign out_data  = data_q;
    assign out_valid = valid_q & ena;
    assign out_last  = last_q;

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: randomized register contents and handshake
// patterns compared against an expected byte list built from the register array.
module tb_reg_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ena, start, out_ready;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  out_data;

    logic        ena2, start2, ready2;
    logic        busy2, done2, valid2, last2;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data2;
    logic [7:0]  data2;

    logic [31:0] regs [32];
    assign rd_data  = regs[rd_addr];
    assign rd_data2 = regs[rd_addr2];

    int errors = 0;
    int checks = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    reg_dump dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    reg_dump #(.FIRST_REG(2), .LAST_REG(3)) dut2 (
        .clk(clk), .rst(rst), .ena(ena2), .start(start2), .busy(busy2), .done(done2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .out_data(data2),
        .out_valid(valid2), .out_ready(ready2), .out_last(last2)
    );

    // Expected stream: per register a header then the word most significant byte first.
    function automatic void build_exp(input int first, input int last);
        exp_q.delete();
        for (int r = first; r <= last; r++) begin
            exp_q.push_back({3'b101, 5'(r)});
            for (int b = 3; b >= 0; b--) exp_q.push_back(regs[r][8*b +: 8]);
        end
    endfunction

    function automatic int stream_mismatches();
        int mm = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got.size() || got[i] !== exp_q[i]) mm++;
        return mm;
    endfunction

    // Runs one dump on dut, collecting accepted bytes and the cycles the spec says get added.
    task automatic run_dump(input int ready_low_pct, input int ena_low_pct, input bit start_noise,
                            input int max_cyc, output bit to, output int done_cyc,
                            output int extra, output int stab_err, output int last_cnt,
                            output int last_pos);
        logic [7:0] pv_data;
        logic       pv_last;
        bit         pv_hold;
        got.delete();
        to = 1'b1; done_cyc = -1; extra = 0; stab_err = 0; last_cnt = 0; last_pos = -1;
        pv_hold = 1'b0; pv_data = 8'h00; pv_last = 1'b0;
        @(negedge clk); ena = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            ena       = ($urandom_range(99) < ena_low_pct)   ? 1'b0 : 1'b1;
            out_ready = ($urandom_range(99) < ready_low_pct) ? 1'b0 : 1'b1;
            start     = start_noise ? 1'($urandom_range(1)) : 1'b0;
            #1;
            if (!ena) begin
                extra++;
                if (out_valid) stab_err++;
            end else if (out_valid && !out_ready) extra++;
            if (pv_hold && ena && !(out_valid && out_data == pv_data && out_last == pv_last)) stab_err++;
            if (done) begin
                done_cyc = c; to = 1'b0; break;
            end
            if (ena && out_valid) begin
                pv_hold = !out_ready; pv_data = out_data; pv_last = out_last;
                if (out_ready) begin
                    got.push_back(out_data);
                    if (out_last) begin last_cnt++; last_pos = got.size() - 1; end
                end
            end
            @(negedge clk);
        end
        start = 1'b0; ena = 1'b1; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; ena = 1'b0; start = 1'b0; out_ready = 1'b0;
        ena2 = 1'b0; start2 = 1'b0; ready2 = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0h want=0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h want=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got=%0h want=0", out_last); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%0h want=00", out_data); end
        checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL rst_addr got=%0d want=0", rd_addr); end
        checks++; if (rd_addr2 !== 5'd2) begin errors++; $display("FAIL rst_addr2 got=%0d want=2", rd_addr2); end
        rst = 1'b0;
        @(negedge clk); ena = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0h want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%0h want=0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0h want=0", out_valid); end
        checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL midrst_addr got=%0d want=0", rd_addr); end
        bad = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (done || out_valid || busy) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_quiet got=%0d want=0", bad); end
    endtask

    task automatic test_full_dump();
        bit to; int dc, extra, stab, lc, lp;
        logic [7:0] head[10];
        logic [7:0] tail[5];
        int mm;
        head = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA1, 8'h12, 8'h34, 8'h56, 8'h78};
        tail = '{8'hBF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'h0; regs[1] = 32'h12345678; regs[31] = 32'hDEADBEEF;
        build_exp(0, 31);
        run_dump(0, 0, 1'b0, 2000, to, dc, extra, stab, lc, lp);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL full_timeout got=%0d want=0", to); end
        checks++; if (got.size() !== 160) begin errors++; $display("FAIL full_count got=%0d want=160", got.size()); end
        mm = 0;
        for (int i = 0; i < 10; i++) if (i >= got.size() || got[i] !== head[i]) mm++;
        for (int i = 0; i < 5; i++) if (155 + i >= got.size() || got[155+i] !== tail[i]) mm++;
        checks++; if (mm !== 0) begin errors++; $display("FAIL full_head_tail got=%0d bad want=0", mm); end
        checks++; if (stream_mismatches() !== 0) begin errors++; $display("FAIL full_stream got=%0d bad want=0", stream_mismatches()); end
        checks++; if (lc !== 1 || lp !== 159) begin errors++; $display("FAIL full_last got=%0d@%0d want=1@159", lc, lp); end
        checks++; if (dc !== 193) begin errors++; $display("FAIL full_done_cycle got=%0d want=193", dc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_in_done got=%0h want=1", busy); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL full_idle got=%0h%0h want=00", busy, done); end
    endtask

    task automatic test_backpressure();
        bit found, to; int dc, extra, stab, lc, lp, n;
        regs[1] = 32'h12345678;
        found = 1'b0;
        @(negedge clk); ena = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (out_valid && out_data == 8'hA1) begin out_ready = 1'b0; found = 1'b1; break; end
            out_ready = 1'b1;
            @(negedge clk);
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL bp_find_a1 got=%0d want=1", found); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin errors++; $display("FAIL bp_hold got=%0h/%0h want=1/a1", out_valid, out_data); end
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h12) begin errors++; $display("FAIL bp_resume got=%0h/%0h want=1/12", out_valid, out_data); end
        n = 0;
        while (!done && n < 400) begin @(negedge clk); #1; n++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_drain got=%0h want=1", done); end
        @(negedge clk);
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        build_exp(0, 31);
        run_dump(40, 0, 1'b0, 2000, to, dc, extra, stab, lc, lp);
        checks++; if (stream_mismatches() !== 0 || got.size() !== 160) begin errors++; $display("FAIL bp_stream got=%0d bad/%0d want=0/160", stream_mismatches(), got.size()); end
        checks++; if (stab !== 0) begin errors++; $display("FAIL bp_stable got=%0d want=0", stab); end
        checks++; if (dc !== 193 + extra) begin errors++; $display("FAIL bp_done_cycle got=%0d want=%0d", dc, 193 + extra); end
        checks++; if (lc !== 1 || lp !== 159) begin errors++; $display("FAIL bp_last got=%0d@%0d want=1@159", lc, lp); end
        @(negedge clk);
    endtask

    task automatic test_ena_start();
        bit found, to; int n, c, dc, extra, stab, lc, lp;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        build_exp(0, 31);
        found = 1'b0; n = 0;
        @(negedge clk); ena = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (c = 0; c < 300; c++) begin
            #1;
            if (out_valid && n == 17) begin found = 1'b1; break; end
            if (out_valid) n++;
            start = (n >= 6 && n <= 8) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL ena_find got=%0d want=1", found); end
        for (int i = 0; i < 4; i++) begin
            ena = 1'b0; #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ena_valid_low got=%0h want=0", out_valid); end
            @(negedge clk);
        end
        ena = 1'b1; #1;
        checks++; if (out_valid !== 1'b1 || out_data !== exp_q[17]) begin errors++; $display("FAIL ena_resume got=%0h/%0h want=1/%0h", out_valid, out_data, exp_q[17]); end
        start = 1'b1;
        for (c = 0; c < 400; c++) begin
            if (done) break;
            if (out_valid) n++;
            @(negedge clk); #1;
        end
        start = 1'b0;
        checks++; if (n !== 160) begin errors++; $display("FAIL start_busy_count got=%0d want=160", n); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_not_queued got=%0h want=0", busy); end
        build_exp(0, 31);
        run_dump(30, 25, 1'b1, 3000, to, dc, extra, stab, lc, lp);
        checks++; if (stream_mismatches() !== 0 || got.size() !== 160) begin errors++; $display("FAIL ena_rand_stream got=%0d bad/%0d want=0/160", stream_mismatches(), got.size()); end
        checks++; if (stab !== 0) begin errors++; $display("FAIL ena_rand_stable got=%0d want=0", stab); end
        checks++; if (dc !== 193 + extra) begin errors++; $display("FAIL ena_rand_done got=%0d want=%0d", dc, 193 + extra); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_rand_idle got=%0h want=0", busy); end
    endtask

    task automatic test_reset_mid_dump();
        bit found, to; int n, bad, dc, extra, stab, lc, lp;
        found = 1'b0; n = 0;
        @(negedge clk); ena = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (out_valid && n == 25) begin found = 1'b1; break; end
            if (out_valid) n++;
            @(negedge clk);
        end
        checks++; if (found !== 1'b1 || rd_addr !== 5'd5) begin errors++; $display("FAIL mid_reach_r5 got=%0d/%0d want=1/5", found, rd_addr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (done || out_valid || busy) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_no_done got=%0d want=0", bad); end
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        build_exp(0, 31);
        run_dump(20, 0, 1'b0, 2000, to, dc, extra, stab, lc, lp);
        checks++; if (got.size() == 0 || got[0] !== 8'hA0) begin errors++; $display("FAIL mid_restart_a0 got=%0h want=a0", (got.size() == 0) ? 8'hxx : got[0]); end
        checks++; if (stream_mismatches() !== 0 || got.size() !== 160) begin errors++; $display("FAIL mid_restart_stream got=%0d bad/%0d want=0/160", stream_mismatches(), got.size()); end
        @(negedge clk);
    endtask

    task automatic test_coherence();
        logic [31:0] old2;
        logic [7:0]  s[$];
        logic [7:0]  want[10];
        bit written, fin;
        int lp, lc, mm;
        old2 = $urandom; regs[2] = old2; regs[3] = $urandom;
        want = '{8'hA2, old2[31:24], old2[23:16], old2[15:8], old2[7:0],
                 8'hA3, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        written = 1'b0; fin = 1'b0; lp = -1; lc = 0;
        @(negedge clk); ena2 = 1'b1; start2 = 1'b1; ready2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (done2) begin fin = 1'b1; break; end
            if (valid2) begin
                if (data2 == 8'hA2 && !written) begin
                    regs[2] = 32'h1; regs[3] = 32'hCAFEF00D; written = 1'b1;
                end
                s.push_back(data2);
                if (last2) begin lc++; lp = s.size() - 1; end
            end
            @(negedge clk);
        end
        checks++; if (fin !== 1'b1 || s.size() !== 10) begin errors++; $display("FAIL coh_len got=%0d/%0d want=1/10", fin, s.size()); end
        mm = 0;
        for (int i = 0; i < 10; i++) if (i >= s.size() || s[i] !== want[i]) mm++;
        checks++; if (mm !== 0) begin errors++; $display("FAIL coh_bytes got=%0d bad want=0", mm); end
        checks++; if (lc !== 1 || lp !== 9) begin errors++; $display("FAIL coh_last got=%0d@%0d want=1@9", lc, lp); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_ena_start();
        test_reset_mid_dump();
        test_coherence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug reader for the CPU register file used during board bring-up. On a start pulse it walks a range of registers through one read port, captures each 32-bit value, and streams it out as a byte stream with a valid/ready handshake. The stream feeds the board UART or display serializer. It sits beside the datapath as a second reader of the register file and never writes to it.

## Interface

Parameters:
- FIRST_REG, default 0: first register index dumped (0..31).
- LAST_REG, default 31: last register index dumped (FIRST_REG..31).

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  block enable. When 0, all state holds and out_valid is forced to 0.
- start  in  1  begins a dump when sampled high in IDLE with ena=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final byte is accepted.
- rd_addr  out  5  register file read address.
- rd_data  in  32  register file read data. It is combinational from rd_addr, so it is valid in the same cycle.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte.
- out_last  out  1  high together with the final byte of the dump.

## Operation

- Byte format per register, 5 bytes in order:
  - Header byte {3'b101, addr[4:0]}.
  - Then data[31:24], data[23:16], data[15:8], data[7:0].
- A full default dump is 32×5 = 160 bytes.
- State machine states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - rd_addr = FIRST_REG; out_valid = 0.
  - start & ena → LOAD.
- LOAD:
  - rd_addr = current index.
  - Capture rd_data into the 32-bit word register.
  - Clear byte_idx (3 bits) to 0.
  - → SEND.
- SEND:
  - out_valid = 1.
  - out_data = header when byte_idx = 0, otherwise the word byte selected by byte_idx.
  - On handshake (out_valid & out_ready):
    - If byte_idx < 4: byte_idx increments.
    - Else if index = LAST_REG: → DONE.
    - Else: index increments, → LOAD.
- DONE:
  - done = 1 for one cycle, then → IDLE.
- out_last = SEND & index = LAST_REG & byte_idx = 4.
- Coherence is per register only:
  - A value is frozen at its LOAD cycle.
  - Writes to a register after its LOAD are not reflected.
  - Writes to later registers are reflected.
- start while busy is ignored. It is not queued.
- ena = 0 in any state:
  - State, index, byte_idx and the word register hold.
  - out_valid = 0 and out_ready is ignored, so no handshake is counted.
  - done is masked.
- While out_valid is high, out_data and out_last hold stable until the handshake.
- Index arithmetic is 5-bit. LAST_REG = 31 terminates the dump, so the index never wraps.

## Timing

- Reset values:
  - State = IDLE, busy = 0, done = 0.
  - out_valid = 0, out_last = 0, out_data = 0.
  - rd_addr = FIRST_REG, word = 0, byte_idx = 0.
- Reset mid-dump: IDLE on the next cycle, with no done and no further bytes.
- With start sampled at edge 0, ena = 1 and out_ready constantly 1:
  - Register k (relative to FIRST_REG) is in LOAD in cycle 6k+1.
  - Its bytes are presented in cycles 6k+2 … 6k+6.
- Full default dump:
  - Last byte in cycle 192.
  - done high in cycle 193.
  - busy falls in cycle 194.
- Throughput: 5 bytes per 6 cycles, because LOAD is a one-cycle bubble.
- Backpressure adds one cycle per low out_ready cycle in SEND.

## Test plan

- Reset: assert rst 2 cycles mid-operation → busy = 0, done = 0, out_valid = 0, rd_addr = 0 on the following cycle.
- Full dump, default parameters, r1 = 0x12345678, r31 = 0xDEADBEEF, out_ready = 1:
  - Stream begins A0 00 00 00 00 A1 12 34 56 78.
  - Stream ends BF DE AD BE EF, with out_last only on 0xEF.
  - done pulses in cycle 193 after start.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles while 0xA1 is presented → out_data stays 0xA1 and out_valid stays 1.
  - Raise out_ready → 0x12 follows next.
- Enable and start gating:
  - ena = 0 for 4 cycles during reg 3 data byte 2 → out_valid = 0 throughout, and the stream resumes at that same byte.
  - start pulsed while busy → no restart, and the byte count stays 160.
- Reset mid-dump at reg 5 → no done. A new start emits A0 first, i.e. the dump restarts at FIRST_REG.
- Coherence and range, with FIRST_REG = 2, LAST_REG = 3:
  - Write r2 = 0x1 during r2 SEND and r3 = 0xCAFEF00D before r3 LOAD.
  - Stream is 10 bytes: A2 + the old r2 value, then A3 CA FE F0 0D with out_last on 0x0D.
